// File: rtl/lct_tx.sv
// lct_tx: transmit end of the ALCT trigger output path.
//
// Every BX in which at least one LCT or a shower bit is present (and capture
// is enabled) is tagged with the local bunch-crossing number. It is buffered
// in a FIFO and sent to the TMB as two 18-bit words.
//   word 0 = entry[35:18] = {bxn, shower, lct1[10:7]}   (tx_first = 1)
//   word 1 = entry[17:0]  = {lct1[6:0], lct0}           (tx_first = 0)
//
// Handshake: a word transfers on a rising clk edge where tx_valid and
// tx_ready are both 1. While tx_valid is 1 and the word has not transferred,
// tx_data and tx_first hold their values. tx_valid never depends on tx_ready.
//
// Ports:
//   clk, rst_n             BX clock, asynchronous active-low reset
//   hv/hp/hnp/hfap         best LCT: valid, quality, key wiregroup, accel flag
//   lv/lp/lnp/lfap         second LCT: same fields
//   shower_int             shower (HMT) bits
//   bc0                    bunch-counter zero marker (next bxn = 0)
//   tx_en                  capture enable (buffered entries drain regardless)
//   ovf_clr                clears the overflow counter
//   tx_data/valid/first    link word, valid, word-0 marker
//   tx_ready               sink accepts word
//   fifo_empty/fifo_full   registered FIFO occupancy flags
//   ovf_cnt                saturating count of entries dropped on overflow
module lct_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int BX_MAX     = 3563
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hv,
  input  logic [1:0]  hp,
  input  logic [6:0]  hnp,
  input  logic        hfap,
  input  logic        lv,
  input  logic [1:0]  lp,
  input  logic [6:0]  lnp,
  input  logic        lfap,
  input  logic [1:0]  shower_int,
  input  logic        bc0,
  input  logic        tx_en,
  input  logic        ovf_clr,
  output logic [17:0] tx_data,
  output logic        tx_valid,
  output logic        tx_first,
  input  logic        tx_ready,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [7:0]  ovf_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, W0, W1} state_t;

  state_t          state, state_nx;
  logic [11:0]     bxn;
  logic            cap_valid;
  logic [35:0]     cap_entry;
  logic [10:0]     lct_h, lct_l, lct0, lct1;
  logic [35:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, hs, pop, drop, wr;
  logic [35:0]     head, next_head;
  logic [17:0]     data_nx;
  logic            valid_nx, first_nx;

  // Bunch-crossing counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  bxn <= '0;
    else if (bc0)                bxn <= '0;
    else if (bxn == 12'(BX_MAX)) bxn <= '0;
    else                         bxn <= bxn + 12'd1;
  end

  // Capture stage: the second LCT is promoted to slot 0 when the best is absent
  always_comb begin
    lct_h = {hv, hp, hfap, hnp};
    lct_l = {lv, lp, lfap, lnp};
    lct0  = hv ? lct_h : (lv ? lct_l : 11'd0);
    lct1  = (hv && lv) ? lct_l : 11'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_entry <= '0;
    end else begin
      cap_valid <= tx_en && (hv || lv || (shower_int != 2'b00));
      cap_entry <= {bxn, shower_int, lct1, lct0};
    end
  end

  // FIFO bookkeeping. A write into a full FIFO is accepted only when the
  // serializer pops in the same cycle.
  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign hs   = tx_valid && tx_ready;
  assign drop = cap_valid && full && !pop;
  assign wr   = cap_valid && !drop;

  // The entry the serializer loads next. When the FIFO is empty the entry
  // being written this cycle is forwarded, so word 0 appears the cycle after
  // the write instead of one cycle later.
  assign head      = (count == '0) ? cap_entry : mem[rd_ptr];
  assign next_head = (count > (AW+1)'(1)) ? mem[rd_ptr + AW'(1)] : cap_entry;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= cap_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = full;

  // Overflow counter: a clear and a drop in the same cycle leave 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ovf_cnt <= '0;
    else if (ovf_clr)                  ovf_cnt <= drop ? 8'd1 : 8'd0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end

  // Serializer FSM; link outputs are registered and loaded on transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_first <= 1'b0;
    end else begin
      state    <= state_nx;
      tx_data  <= data_nx;
      tx_valid <= valid_nx;
      tx_first <= first_nx;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = tx_data;
    valid_nx = tx_valid;
    first_nx = tx_first;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty || cap_valid) begin
          state_nx = W0;
          data_nx  = head[35:18];
          valid_nx = 1'b1;
          first_nx = 1'b1;
        end
      end
      W0: begin
        if (hs) begin
          state_nx = W1;
          data_nx  = head[17:0];
          first_nx = 1'b0;
        end
      end
      W1: begin
        if (hs) begin
          pop = 1'b1;
          if (count > (AW+1)'(1) || cap_valid) begin
            state_nx = W0;
            data_nx  = next_head[35:18];
            first_nx = 1'b1;
          end else begin
            state_nx = IDLE;
            valid_nx = 1'b0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        first_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lct_tx.sv
// Testbench for lct_tx: directed events, expected link words queued at issue
// time and checked by an independent monitor on every accepted word.
module tb_lct_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hv, hfap, lv, lfap, bc0, tx_en, ovf_clr, tx_ready;
  logic [1:0]  hp, lp, shower_int;
  logic [6:0]  hnp, lnp;
  logic [17:0] tx_data;
  logic        tx_valid, tx_first, fifo_empty, fifo_full;
  logic [7:0]  ovf_cnt;

  logic [18:0] exp_q[$];   // {tx_first, tx_data}
  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] m_bxn;

  lct_tx #(.FIFO_DEPTH(8), .BX_MAX(3563)) dut (
    .clk(clk), .rst_n(rst_n),
    .hv(hv), .hp(hp), .hnp(hnp), .hfap(hfap),
    .lv(lv), .lp(lp), .lnp(lnp), .lfap(lfap),
    .shower_int(shower_int), .bc0(bc0), .tx_en(tx_en), .ovf_clr(ovf_clr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_first(tx_first),
    .tx_ready(tx_ready), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .ovf_cnt(ovf_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference bunch-crossing counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               m_bxn <= '0;
    else if (bc0)             m_bxn <= '0;
    else if (m_bxn == 12'd3563) m_bxn <= '0;
    else                      m_bxn <= m_bxn + 12'd1;
  end

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] form(input logic [11:0] b, input logic [1:0] sh,
      input logic h_v, input logic [1:0] h_p, input logic [6:0] h_np, input logic h_fa,
      input logic l_v, input logic [1:0] l_p, input logic [6:0] l_np, input logic l_fa);
    logic [10:0] a, c;
    a = '0;
    c = '0;
    if (h_v) begin
      a = {1'b1, h_p, h_fa, h_np};
      if (l_v) c = {1'b1, l_p, l_fa, l_np};
    end else if (l_v) begin
      a = {1'b1, l_p, l_fa, l_np};
    end
    return {b, sh, c, a};
  endfunction

  task automatic push_entry(input logic [35:0] e);
    exp_q.push_back({1'b1, e[35:18]});
    exp_q.push_back({1'b0, e[17:0]});
  endtask

  task automatic push_words(input logic [17:0] w0, input logic [17:0] w1);
    exp_q.push_back({1'b1, w0});
    exp_q.push_back({1'b0, w1});
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bc0_pulse();
    bc0 = 1'b1;
    step();
    bc0 = 1'b0;
  endtask

  // Drive one BX of candidates; optionally queue the modelled entry
  task automatic ev(input logic h_v, input logic [1:0] h_p, input logic [6:0] h_np,
      input logic h_fa, input logic l_v, input logic [1:0] l_p, input logic [6:0] l_np,
      input logic l_fa, input logic [1:0] sh, input bit model_push);
    hv = h_v; hp = h_p; hnp = h_np; hfap = h_fa;
    lv = l_v; lp = l_p; lnp = l_np; lfap = l_fa;
    shower_int = sh;
    if (model_push) push_entry(form(m_bxn, sh, h_v, h_p, h_np, h_fa, l_v, l_p, l_np, l_fa));
    step();
    hv = 0; hp = 0; hnp = 0; hfap = 0;
    lv = 0; lp = 0; lnp = 0; lfap = 0;
    shower_int = 0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tx_valid && k < 20);
    if (!tx_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: tx_valid not seen within 20 cycles", name);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: %0d words still expected after 200 cycles", name, exp_q.size());
    end
    idle(2);
  endtask

  // scoreboard monitor
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got first=%0b data=0x%h, expected none", tx_first, tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_word", {17'd0, tx_first, tx_data}, {17'd0, e});
        end
      end
    end
  end

  initial begin
    logic [17:0] d0;
    logic        f0;
    rst_n = 0; bc0 = 0; tx_en = 1; ovf_clr = 0; tx_ready = 0;
    hv = 0; hp = 0; hnp = 0; hfap = 0; lv = 0; lp = 0; lnp = 0; lfap = 0; shower_int = 0;
    idle(3);
    check("rst_tx_valid", 36'(tx_valid), 36'd0);
    check("rst_tx_first", 36'(tx_first), 36'd0);
    check("rst_tx_data", 36'(tx_data), 36'd0);
    check("rst_fifo_empty", 36'(fifo_empty), 36'd1);
    check("rst_fifo_full", 36'(fifo_full), 36'd0);
    check("rst_ovf_cnt", 36'(ovf_cnt), 36'd0);
    rst_n = 1;
    idle(2);

    // single event at bxn 5, with latency check
    tx_ready = 1;
    bc0_pulse();
    idle(5);
    push_words({12'd5, 2'b00, 4'b0000}, {7'd0, 11'b1_11_1_0101010});
    ev(1, 2'd3, 7'h2A, 1, 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    check("latency_n1_valid", 36'(tx_valid), 36'd0);
    @(negedge clk);
    check("latency_n2_valid", 36'(tx_valid), 36'd1);
    check("latency_n2_first", 36'(tx_first), 36'd1);
    drain("single");

    // promotion swap, shower-only, both LCTs valid
    bc0_pulse();
    push_words({12'd0, 2'b10, 4'b0000}, {7'd0, 11'b1_10_0_0010001});
    ev(0, 0, 0, 0, 1, 2'd2, 7'h11, 0, 2'b10, 0);
    push_words({12'd1, 2'b01, 4'b0000}, 18'd0);
    ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    push_words({12'd2, 2'b00, 4'b1111}, {7'b0000101, 11'b1_01_0_1111111});
    ev(1, 2'd1, 7'h7F, 0, 1, 2'd3, 7'h05, 1, 2'b00, 0);
    drain("swap_shower");

    // capture disabled
    tx_en = 0;
    ev(1, 2'd3, 7'h01, 0, 1, 2'd1, 7'h02, 0, 2'b11, 0);
    idle(3);
    check("tx_en0_empty", 36'(fifo_empty), 36'd1);
    check("tx_en0_valid", 36'(tx_valid), 36'd0);
    tx_en = 1;

    // back-pressure in W0
    tx_ready = 0;
    ev(1, 2'd2, 7'h33, 0, 0, 0, 0, 0, 2'b00, 1);
    wait_valid("bp_valid");
    d0 = tx_data;
    f0 = tx_first;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_data", 36'(tx_data), 36'(d0));
      check("bp_hold_first", 36'({tx_valid, tx_first}), 36'({1'b1, f0}));
    end
    @(posedge clk);
    #1;
    tx_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp_word1_next", 36'({tx_valid, tx_first}), 36'b10);
    drain("backpressure");

    // three entries stream as six gap-free words
    tx_ready = 0;
    for (int i = 0; i < 3; i++) ev(1, 2'(i), 7'(i + 9), 1, 1, 2'd1, 7'(40 + i), 0, 2'(i), 1);
    wait_valid("b2b_valid");
    @(posedge clk);
    #1;
    tx_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b2b_no_gap", 36'({tx_valid, tx_first}), 36'({1'b1, (i % 2 == 0)}));
    end
    @(negedge clk);
    check("b2b_end_idle", 36'(tx_valid), 36'd0);
    drain("b2b");

    // overflow: 10 events into an 8-deep FIFO with the sink stalled
    tx_ready = 0;
    for (int i = 0; i < 10; i++) ev(1, 2'(i), 7'(i * 5), 0, 1'(i), 2'd3, 7'(i), 1, 2'b00, (i < 8));
    step();
    check("ovf_full", 36'(fifo_full), 36'd1);
    check("ovf_cnt_2", 36'(ovf_cnt), 36'd2);
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    check("ovf_clr", 36'(ovf_cnt), 36'd0);
    for (int i = 0; i < 300; i++) ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    step();
    check("ovf_saturate", 36'(ovf_cnt), 36'd255);
    tx_ready = 1;
    drain("ovf_drain");
    check("ovf_drained_empty", 36'(fifo_empty), 36'd1);

    // bxn wrap and mid-run bc0
    bc0_pulse();
    idle(3563);
    push_words({12'd3563, 2'b00, 4'b0000}, {7'd0, 11'b1_01_0_0000001});
    ev(1, 2'd1, 7'h01, 0, 0, 0, 0, 0, 2'b00, 0);
    push_words({12'd0, 2'b00, 4'b0000}, {7'd0, 11'b1_01_0_0000001});
    ev(1, 2'd1, 7'h01, 0, 0, 0, 0, 0, 2'b00, 0);
    idle(7);
    bc0_pulse();
    push_words({12'd0, 2'b11, 4'b0000}, 18'd0);
    ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
    drain("bxn_wrap");

    // reset during W1 with three entries queued (ovf_cnt is still 255)
    tx_ready = 0;
    for (int i = 0; i < 3; i++) ev(1, 2'd2, 7'(i + 100), 1, 0, 0, 0, 0, 2'b00, 1);
    wait_valid("rst_mid_valid");
    @(posedge clk);
    #1;
    tx_ready = 1;
    step();
    tx_ready = 0;
    rst_n = 0;
    #1;
    exp_q.delete();
    check("rstmid_valid", 36'(tx_valid), 36'd0);
    check("rstmid_empty", 36'(fifo_empty), 36'd1);
    check("rstmid_ovf", 36'(ovf_cnt), 36'd0);
    idle(2);
    rst_n = 1;
    idle(2);
    tx_ready = 1;
    ev(0, 0, 0, 0, 1, 2'd1, 7'h5A, 1, 2'b00, 1);
    drain("after_reset");
    check("final_empty", 36'(fifo_empty), 36'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lct_tx.md
Name: lct_tx

Overview:
- Transmit end of the ALCT trigger output path.
- Samples the per-BX best/second LCT candidates and the shower bits produced by the pattern-finding chain.
- Tags each non-empty BX with a bunch-crossing number, buffers it in a small FIFO, and serializes each entry as two 18-bit words toward the TMB link under a valid/ready handshake.
- Absorbs trigger bursts; counts entries lost on overflow.

Parameters:
- FIFO_DEPTH, 8, entries in the buffer; power of 2, minimum 2.
- BX_MAX, 3563, last BX number before bxn wraps to 0.

Ports:
- clk  in  1  40 MHz BX clock.
- rst_n  in  1  reset; asynchronous, active-low.
- hv  in  1  best LCT valid.
- hp  in  2  best LCT quality.
- hnp  in  7  best LCT key wiregroup.
- hfap  in  1  best LCT accelerator flag.
- lv  in  1  second LCT valid.
- lp  in  2  second LCT quality.
- lnp  in  7  second LCT key wiregroup.
- lfap  in  1  second LCT accelerator flag.
- shower_int  in  2  shower (HMT) bits.
- bc0  in  1  bunch-counter zero marker.
- tx_en  in  1  capture enable.
- ovf_clr  in  1  clears overflow counter.
- tx_data  out  18  link word.
- tx_valid  out  1  tx_data valid.
- tx_first  out  1  marks word 0 of an entry.
- tx_ready  in  1  sink accepts word.
- fifo_empty  out  1  FIFO empty.
- fifo_full  out  1  FIFO full.
- ovf_cnt  out  8  dropped-entry count, saturating.

Behaviour:
- Reset (async on rst_n low): tx_data=0, tx_valid=0, tx_first=0, fifo_empty=1, fifo_full=0, ovf_cnt=0, bxn=0, FIFO pointers=0.
- Reset mid-transfer aborts the transfer and discards the FIFO contents.
- bxn (12 bit, internal):
  - bc0=1 → next bxn=0.
  - else bxn==BX_MAX → 0.
  - else bxn+1.
- Capture stage (registered, cycle N): when tx_en=1 and (hv|lv|shower_int!=0), form the entry from the cycle-N inputs and the cycle-N bxn. LCT field = {v, q[1:0], fa, wg[6:0]} (11 bits).
  - hv=1: lct0=best, lct1 = lv ? second : 0.
  - hv=0, lv=1: lct0=second, lct1=0 (promotion swap).
  - Neither valid: lct0=lct1=0 (shower-only entry).
  - entry = {bxn[11:0], shower[1:0], lct1[10:0], lct0[10:0]} (36 bits).
- FIFO write happens at N+1.
- Earliest tx_valid is N+2, with word 0 of that entry.
- Serializer FSM states: IDLE, W0, W1.
  - IDLE→W0 when FIFO non-empty: tx_data=entry[35:18], tx_first=1, tx_valid=1.
  - W0→W1 on tx_valid&tx_ready: tx_data=entry[17:0], tx_first=0.
  - W1 on handshake: pop the entry. Go to W0 if another entry is present (back-to-back, no idle cycle), else IDLE (tx_valid=0).
  - While tx_valid=1 and tx_ready=0, tx_data and tx_first are held stable.
  - Peak throughput is 1 entry per 2 cycles.
- FIFO boundaries:
  - Write when full and no pop that cycle: entry dropped; ovf_cnt+1, saturating at 255.
  - Write when full with a simultaneous pop (W1 handshake): write accepted; count unchanged; fifo_full stays 1.
  - ovf_clr=1 → ovf_cnt=0 next cycle. If a drop occurs in the same cycle, ovf_cnt=1.
  - fifo_full and fifo_empty reflect the registered occupancy after the current cycle's write/pop.
- tx_en=0 blocks new captures only; buffered entries still drain.
- Entry order is strictly FIFO. Words are never reordered or duplicated.

Test Plan:
- Single event: bc0 pulse, then 5 cycles later hv=1, hp=3, hnp=0x2A, hfap=1, lv=0, shower=0 → 2 cycles later tx_first=1 word0 = {12'd5, 2'b00, 4'b0000}. Next word1 = {7'd0, 11'b1_11_1_0101010}.
- Swap and shower: hv=0, lv=1, lp=2, lnp=0x11, lfap=0, shower=2'b10 → lct0=11'b1_10_0_0010001, lct1=0, shower field=2. Shower-only BX (hv=lv=0, shower=1) → entry with both LCTs zero.
- Back-pressure: tx_ready=0 for 4 cycles during W0 → tx_data/tx_first stable. Release → word1 follows the next cycle. 3 queued entries stream as 6 consecutive words with no gaps.
- Overflow: tx_ready=0, 10 consecutive valid BXs with FIFO_DEPTH=8 → fifo_full=1, ovf_cnt=2. ovf_clr → 0. 300 further drops → ovf_cnt=255.
- bxn wrap: no bc0 for 3564 cycles → entries at bxn 3563 then 0. bc0 asserted mid-run → next entry tagged bxn=0 (bc0 cycle+1).
- Reset mid-transfer: rst_n low during W1 with 3 entries queued → immediately tx_valid=0, fifo_empty=1, ovf_cnt=0. After release, the first new event is transmitted normally.
